// File: rtl/user_module_rr_grant_ctrl_if.sv
// user_module_rr_grant_ctrl_if: request/grant bundle between the requesters and the round-robin arbiter
interface user_module_rr_grant_ctrl_if;
    logic [3:0] req;
    logic       en;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       all_req;
    modport master (output req, en, rel, input gnt, gnt_idx, busy, all_req);
    modport slave (input req, en, rel, output gnt, gnt_idx, busy, all_req);
endinterface

// File: rtl/user_module_rr_grant_ctrl.sv
// user_module_rr_grant_ctrl: 4-way round-robin arbiter with bounded hold, one-cycle gap between owners
module user_module_rr_grant_ctrl #(
    parameter int HOLD_CYCLES = 4
) (
    input logic clk,
    input logic rst,
    user_module_rr_grant_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t     r_state;
    logic [1:0] r_last;
    logic [2:0] r_cnt;
    logic [3:0] r_gnt;
    logic [1:0] r_idx;
    logic       r_busy;
    logic       r_all;
    logic [1:0] w_pick;
    logic [1:0] w_cand;
    logic       w_start;
    logic       w_end;
    // walk the rotation backwards so the requester closest after r_last wins
    always_comb begin
        w_pick = r_last;
        w_cand = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_cand = r_last + 2'(k);
            if (bus.req[w_cand]) w_pick = w_cand;
        end
    end
    assign w_start = bus.en & |bus.req;
    assign w_end = !bus.en | !bus.req[r_idx] | bus.rel | (r_cnt == 3'(HOLD_CYCLES));
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= 2'd3;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_all   <= 1'b0;
        end else begin
            r_all <= &bus.req;
            case (r_state)
                GRANT: begin
                    if (w_end) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_last  <= r_idx;
                        r_state <= GAP;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: begin
                    if (w_start) begin
                        r_gnt   <= 4'b0001 << w_pick;
                        r_idx   <= w_pick;
                        r_cnt   <= 3'd1;
                        r_busy  <= 1'b1;
                        r_state <= GRANT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
    assign bus.gnt     = r_gnt;
    assign bus.gnt_idx = r_idx;
    assign bus.busy    = r_busy;
    assign bus.all_req = r_all;
endmodule

// File: tb/tb_user_module_rr_grant_ctrl.sv
// tb_user_module_rr_grant_ctrl: directed + random stimulus against a behavioural round-robin model
module tb_user_module_rr_grant_ctrl;
    localparam int HOLD = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int m_owner, m_held, m_last, m_idx, m_all;
    user_module_rr_grant_ctrl_if bus ();
    user_module_rr_grant_ctrl #(.HOLD_CYCLES(HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    function automatic int pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= 4; k++)
            if (req[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction
    task automatic model_edge();
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = 3; m_idx = 0; m_all = 0;
        end else begin
            m_all = int'(&bus.req);
            if (m_owner >= 0) begin
                if (!bus.en || !bus.req[m_owner] || bus.rel || m_held == HOLD) begin
                    m_last = m_owner;
                    m_owner = -1;
                end else begin
                    m_held++;
                end
            end else if (bus.en && |bus.req) begin
                m_owner = pick(m_last, bus.req);
                m_held = 1;
                m_idx = m_owner;
            end
        end
    endtask
    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, obs, exp);
        end
    endtask
    function automatic logic [7:0] model_out();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
        return {m_all[0], m_owner >= 0, m_idx[1:0], g};
    endfunction
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        chk(tag, {bus.all_req, bus.busy, bus.gnt_idx, bus.gnt}, model_out());
    endtask
    task automatic drive(input logic r, input logic [3:0] q, input logic e, input logic l);
        rst = r; bus.req = q; bus.en = e; bus.rel = l;
    endtask
    initial begin
        logic [3:0] exp_g;
        m_owner = -1; m_held = 0; m_last = 3; m_idx = 0; m_all = 0;
        drive(1, 4'hF, 1, 0);
        tick("t1_reset");
        tick("t1_reset");
        chk("t1_gnt_zero", {4'b0, bus.gnt}, 8'h00);
        drive(0, 4'hF, 1, 0);
        for (int t = 0; t < 21; t++) begin
            tick("t2_rotate");
            exp_g = (t % 5 == 4) ? 4'b0 : 4'(1 << ((t / 5) % 4));
            chk("t2_gnt_seq", {4'b0, bus.gnt}, {4'b0, exp_g});
        end
        drive(1, 4'b0101, 1, 0); tick("t3_reset");
        drive(0, 4'b0101, 1, 0); tick("t3_g1"); tick("t3_g2");
        chk("t3_owner0", {4'b0, bus.gnt}, 8'h01);
        drive(0, 4'b0101, 1, 1); tick("t3_gap");
        chk("t3_gap_zero", {4'b0, bus.gnt}, 8'h00);
        drive(0, 4'b0101, 1, 0); tick("t3_next");
        chk("t3_owner2", {4'b0, bus.gnt}, 8'h04);
        drive(1, 4'b0101, 1, 0); tick("t4_reset");
        drive(0, 4'b0101, 1, 0); tick("t4_g");
        drive(0, 4'b0100, 1, 0); tick("t4_gap"); tick("t4_next");
        chk("t4_owner2", {4'b0, bus.gnt}, 8'h04);
        drive(0, 4'hF, 1, 0); tick("t5_a"); tick("t5_b");
        drive(0, 4'hF, 0, 0); tick("t5_en_gap"); tick("t5_en_idle"); tick("t5_en_idle2");
        chk("t5_idle_zero", {bus.busy, 3'b0, bus.gnt}, 8'h00);
        drive(0, 4'hF, 1, 0); tick("t5_c"); tick("t5_d");
        drive(1, 4'hF, 1, 0); tick("t5_rst");
        chk("t5_rst_zero", {4'b0, bus.gnt}, 8'h00);
        drive(0, 4'hF, 1, 0); tick("t5_after");
        chk("t5_req0_first", {4'b0, bus.gnt}, 8'h01);
        drive(0, 4'b0111, 0, 0); tick("t6_a");
        chk("t6_all0", {7'b0, bus.all_req}, 8'h00);
        drive(0, 4'b1111, 0, 0); tick("t6_b");
        chk("t6_all1", {7'b0, bus.all_req}, 8'h01);
        for (int t = 0; t < 400; t++) begin
            drive($urandom_range(0, 49) == 0, 4'($urandom), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 9) == 0);
            tick("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
